// File: rtl/dfifo_sync_prog_pkg.sv
// dfifo_pkg: shared constants, level type and helpers for the programmable FIFO
package dfifo_pkg;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH = 2 ** ADDR_WIDTH_DEF;
  typedef logic [ADDR_WIDTH_DEF:0] level_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dfifo_sync_prog_if.sv
// dfifo_sync_prog_if: push/pop, threshold, status and error bundle of the FIFO
interface dfifo_sync_prog_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   almost_full_th;
  logic [ADDR_WIDTH:0]   almost_empty_th;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;
  modport master (
    output flush, wr_en, wr_data, rd_en, almost_full_th, almost_empty_th, err_clr,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty, level, overflow, underflow
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en, almost_full_th, almost_empty_th, err_clr,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/dfifo_sync_prog_ram.sv
// dfifo_sync_ram: distributed RAM, synchronous write, asynchronous read, no reset
module dfifo_sync_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // write port: one word per accepted push
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dfifo_sync_prog.sv
// dfifo_sync_prog: single-clock FIFO with FWFT/standard read, programmable thresholds, flush and sticky errors
module dfifo_sync_prog
  import dfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24,
  parameter int FWFT       = 1,
  parameter int AF_DEFAULT = 2 ** ADDR_WIDTH - 4,
  parameter int AE_DEFAULT = 4
) (
  input logic clk,
  input logic rst_n,
  dfifo_sync_prog_if.slave bus
);
  localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;
  typedef logic [ADDR_WIDTH:0] lvl_t;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  lvl_t                  level_q, af_th, ae_th;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] mem_rd;
  // while reset is held the thresholds fall back to their defaults so the flags show reset values
  assign af_th = rst_n ? bus.almost_full_th  : lvl_t'(AF_DEFAULT);
  assign ae_th = rst_n ? bus.almost_empty_th : lvl_t'(AE_DEFAULT);
  assign push = bus.wr_en & ~bus.full;
  assign pop  = bus.rd_en & ~bus.empty;
  assign bus.level        = level_q;
  assign bus.full         = level_q == lvl_t'(FIFO_DEPTH);
  assign bus.empty        = level_q == '0;
  assign bus.almost_full  = level_q >= af_th;
  assign bus.almost_empty = level_q <= ae_th;
  dfifo_sync_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk   (clk),
    .we    (push & ~bus.flush),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rd)
  );
  // pointers and level counter; flush discards any push/pop of the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level_q <= (push & ~pop) ? level_q + 1'b1 : (pop & ~push) ? level_q - 1'b1 : level_q;
    end
  // sticky error flags; a new error wins over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.overflow  <= (bus.wr_en & bus.full)  | (bus.overflow  & ~bus.err_clr);
      bus.underflow <= (bus.rd_en & bus.empty) | (bus.underflow & ~bus.err_clr);
    end
  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data  = bus.empty ? '0 : mem_rd;
      assign bus.rd_valid = ~bus.empty;
    end else begin : g_std
      // standard read: data registered on the pop edge, valid for one cycle
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          bus.rd_valid <= 1'b0;
          bus.rd_data  <= '0;
        end else if (bus.flush) begin
          bus.rd_valid <= 1'b0;
        end else begin
          bus.rd_valid <= pop;
          if (pop) bus.rd_data <= mem_rd;
        end
    end
  endgenerate
endmodule

// File: tb/tb_dfifo_sync_prog.sv
// tb_dfifo_sync_prog: scoreboard bench for FWFT and standard-read FIFO instances
module tb_dfifo_sync_prog;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [23:0] qf[$];
  logic [23:0] qs[$];
  logic [23:0] exp_d;
  logic [11:0] obs_v;
  localparam logic [11:0] RST_V = {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  dfifo_sync_prog_if #(.ADDR_WIDTH(4), .DATA_WIDTH(24)) bf ();
  dfifo_sync_prog_if #(.ADDR_WIDTH(4), .DATA_WIDTH(24)) bs ();

  dfifo_sync_prog #(.ADDR_WIDTH(4), .DATA_WIDTH(24), .FWFT(1)) u_fwft (.clk(clk), .rst_n(rst_n), .bus(bf));
  dfifo_sync_prog #(.ADDR_WIDTH(4), .DATA_WIDTH(24), .FWFT(0)) u_std  (.clk(clk), .rst_n(rst_n), .bus(bs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic idle();
    bf.flush = 0; bf.wr_en = 0; bf.wr_data = '0; bf.rd_en = 0; bf.err_clr = 0;
    bs.flush = 0; bs.wr_en = 0; bs.wr_data = '0; bs.rd_en = 0; bs.err_clr = 0;
    bf.almost_full_th = 5'd12; bf.almost_empty_th = 5'd4;
    bs.almost_full_th = 5'd12; bs.almost_empty_th = 5'd4;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    bf.almost_full_th = 5'd0; bf.almost_empty_th = 5'd0;
    bs.almost_full_th = 5'd0; bs.almost_empty_th = 5'd0;
    @(negedge clk);
    obs_v = {bf.level, bf.empty, bf.full, bf.almost_empty, bf.almost_full, bf.rd_valid, bf.overflow, bf.underflow};
    n_cmp++; if (obs_v !== RST_V) begin n_bad++; $display("FAIL reset_fwft_flags got %h required %h", obs_v, RST_V); end
    obs_v = {bs.level, bs.empty, bs.full, bs.almost_empty, bs.almost_full, bs.rd_valid, bs.overflow, bs.underflow};
    n_cmp++; if (obs_v !== RST_V) begin n_bad++; $display("FAIL reset_std_flags got %h required %h", obs_v, RST_V); end
    n_cmp++; if (bs.rd_data !== 24'h0) begin n_bad++; $display("FAIL reset_std_rd_data got %h required 000000", bs.rd_data); end
    idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      bf.wr_en = 1; bf.wr_data = 24'(i); qf.push_back(24'(i));
      @(negedge clk);
    end
    n_cmp++; if (bf.full !== 1'b1 || bf.level !== 5'd16) begin n_bad++; $display("FAIL fill_full got full=%b level=%0d required full=1 level=16", bf.full, bf.level); end
    bf.wr_data = 24'h11;
    @(negedge clk);
    bf.wr_en = 0;
    n_cmp++; if (bf.overflow !== 1'b1 || bf.level !== 5'd16) begin n_bad++; $display("FAIL overflow got ovf=%b level=%0d required ovf=1 level=16", bf.overflow, bf.level); end
    for (int i = 0; i < 16; i++) begin
      exp_d = qf.pop_front();
      n_cmp++; if (bf.rd_valid !== 1'b1 || bf.rd_data !== exp_d) begin n_bad++; $display("FAIL drain_data[%0d] got v=%b d=%h required v=1 d=%h", i, bf.rd_valid, bf.rd_data, exp_d); end
      bf.rd_en = 1;
      @(negedge clk);
    end
    bf.rd_en = 0;
    n_cmp++; if (bf.empty !== 1'b1 || bf.level !== 5'd0 || bf.rd_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got empty=%b level=%0d v=%b required 1 0 0", bf.empty, bf.level, bf.rd_valid); end
  endtask

  task automatic test_read_latency();
    bs.wr_en = 1; bs.wr_data = 24'hABCDEF; qs.push_back(24'hABCDEF);
    @(negedge clk);
    bs.wr_en = 0;
    n_cmp++; if (bs.rd_valid !== 1'b0 || bs.level !== 5'd1) begin n_bad++; $display("FAIL std_prepop got v=%b level=%0d required v=0 level=1", bs.rd_valid, bs.level); end
    bs.rd_en = 1;
    @(negedge clk);
    bs.rd_en = 0;
    exp_d = qs.pop_front();
    n_cmp++; if (bs.rd_valid !== 1'b1 || bs.rd_data !== exp_d) begin n_bad++; $display("FAIL std_latency got v=%b d=%h required v=1 d=%h", bs.rd_valid, bs.rd_data, exp_d); end
    bs.rd_en = 1;
    @(negedge clk);
    n_cmp++; if (bs.underflow !== 1'b1 || bs.rd_valid !== 1'b0 || bs.rd_data !== 24'hABCDEF) begin n_bad++; $display("FAIL std_underflow got unf=%b v=%b d=%h required 1 0 abcdef", bs.underflow, bs.rd_valid, bs.rd_data); end
    bs.err_clr = 1;
    @(negedge clk);
    n_cmp++; if (bs.underflow !== 1'b1) begin n_bad++; $display("FAIL err_set_wins got unf=%b required 1", bs.underflow); end
    bs.rd_en = 0;
    @(negedge clk);
    bs.err_clr = 0;
    n_cmp++; if (bs.underflow !== 1'b0) begin n_bad++; $display("FAIL err_clr got unf=%b required 0", bs.underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bf.wr_en = 1; bf.wr_data = 24'($urandom); qf.push_back(bf.wr_data);
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      n_cmp++; if (bf.rd_data !== qf[0]) begin n_bad++; $display("FAIL b2b_data[%0d] got %h required %h", i, bf.rd_data, qf[0]); end
      bf.wr_en = 1; bf.rd_en = 1; bf.wr_data = 24'($urandom); qf.push_back(bf.wr_data);
      @(negedge clk);
      void'(qf.pop_front());
      n_cmp++; if (bf.level !== 5'(qf.size())) begin n_bad++; $display("FAIL b2b_level[%0d] got %0d required %0d", i, bf.level, qf.size()); end
    end
    bf.wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bf.rd_valid !== 1'b1 || bf.rd_data !== qf[0]) begin n_bad++; $display("FAIL b2b_drain[%0d] got %h required %h", i, bf.rd_data, qf[0]); end
      bf.rd_en = 1;
      @(negedge clk);
      void'(qf.pop_front());
    end
    bf.rd_en = 0;
  endtask

  task automatic test_thresholds();
    bf.almost_full_th = 5'd12; bf.almost_empty_th = 5'd3;
    for (int k = 1; k <= 12; k++) begin
      bf.wr_en = 1; bf.wr_data = 24'(k * 3); qf.push_back(bf.wr_data);
      @(negedge clk);
      n_cmp++; if (bf.almost_full !== (k >= 12) || bf.almost_empty !== (k <= 3) || bf.level !== 5'(k)) begin n_bad++; $display("FAIL thresh_lvl%0d got af=%b ae=%b level=%0d required af=%b ae=%b", k, bf.almost_full, bf.almost_empty, bf.level, k >= 12, k <= 3); end
    end
    bf.wr_en = 0;
    bf.rd_en = 1;
    @(negedge clk);
    bf.rd_en = 0;
    void'(qf.pop_front());
    n_cmp++; if (bf.almost_full !== 1'b0 || bf.level !== 5'd11) begin n_bad++; $display("FAIL thresh_af_fall got af=%b level=%0d required af=0 level=11", bf.almost_full, bf.level); end
    bf.almost_full_th = 5'd10;
    #1;
    n_cmp++; if (bf.almost_full !== 1'b1) begin n_bad++; $display("FAIL thresh_af_change got %b required 1", bf.almost_full); end
    bf.almost_full_th = 5'd0;
    #1;
    n_cmp++; if (bf.almost_full !== 1'b1) begin n_bad++; $display("FAIL thresh_af_zero got %b required 1", bf.almost_full); end
    bf.almost_empty_th = 5'd16;
    #1;
    n_cmp++; if (bf.almost_empty !== 1'b1) begin n_bad++; $display("FAIL thresh_ae_depth got %b required 1", bf.almost_empty); end
    bf.almost_empty_th = 5'd10;
    #1;
    n_cmp++; if (bf.almost_empty !== 1'b0) begin n_bad++; $display("FAIL thresh_ae_below got %b required 0", bf.almost_empty); end
    bf.almost_full_th = 5'd12; bf.almost_empty_th = 5'd4;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (bf.rd_data !== qf[0]) begin n_bad++; $display("FAIL thresh_pop[%0d] got %h required %h", i, bf.rd_data, qf[0]); end
      bf.rd_en = 1;
      @(negedge clk);
      void'(qf.pop_front());
    end
    bf.rd_en = 0;
  endtask

  task automatic test_flush();
    n_cmp++; if (bf.level !== 5'd9) begin n_bad++; $display("FAIL flush_prelevel got %0d required 9", bf.level); end
    bf.flush = 1; bf.wr_en = 1; bf.rd_en = 1; bf.wr_data = 24'hFFFFFF;
    @(negedge clk);
    bf.flush = 0; bf.wr_en = 0; bf.rd_en = 0;
    qf.delete();
    n_cmp++; if (bf.level !== 5'd0 || bf.empty !== 1'b1 || bf.rd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_state got level=%0d empty=%b v=%b required 0 1 0", bf.level, bf.empty, bf.rd_valid); end
    n_cmp++; if (bf.overflow !== 1'b1 || bf.underflow !== 1'b0) begin n_bad++; $display("FAIL flush_errs got ovf=%b unf=%b required 1 0", bf.overflow, bf.underflow); end
    bf.err_clr = 1;
    @(negedge clk);
    bf.err_clr = 0;
    n_cmp++; if (bf.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b required 0", bf.overflow); end
    for (int i = 0; i < 2; i++) begin
      bs.wr_en = 1; bs.wr_data = 24'h100 + 24'(i); qs.push_back(bs.wr_data);
      @(negedge clk);
    end
    bs.wr_en = 0; bs.rd_en = 1;
    @(negedge clk);
    exp_d = qs.pop_front();
    n_cmp++; if (bs.rd_valid !== 1'b1 || bs.rd_data !== exp_d) begin n_bad++; $display("FAIL std_prflush got v=%b d=%h required v=1 d=%h", bs.rd_valid, bs.rd_data, exp_d); end
    bs.flush = 1;
    @(negedge clk);
    bs.flush = 0; bs.rd_en = 0;
    qs.delete();
    n_cmp++; if (bs.rd_valid !== 1'b0 || bs.level !== 5'd0) begin n_bad++; $display("FAIL std_flush got v=%b level=%0d required v=0 level=0", bs.rd_valid, bs.level); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      bf.wr_en = 1; bf.wr_data = 24'h700 + 24'(i); qf.push_back(bf.wr_data);
      @(negedge clk);
    end
    bf.wr_en = 0;
    n_cmp++; if (bf.level !== 5'd5) begin n_bad++; $display("FAIL arst_prelevel got %0d required 5", bf.level); end
    #2;
    rst_n = 0;
    #1;
    obs_v = {bf.level, bf.empty, bf.full, bf.almost_empty, bf.almost_full, bf.rd_valid, bf.overflow, bf.underflow};
    n_cmp++; if (obs_v !== RST_V || bf.rd_data !== 24'h0) begin n_bad++; $display("FAIL arst_immediate got %h d=%h required %h d=000000", obs_v, bf.rd_data, RST_V); end
    @(negedge clk);
    rst_n = 1;
    qf.delete();
    @(negedge clk);
    bf.wr_en = 1; bf.wr_data = 24'h5A5A5A; qf.push_back(24'h5A5A5A);
    @(negedge clk);
    bf.wr_en = 0;
    exp_d = qf[0];
    n_cmp++; if (bf.rd_valid !== 1'b1 || bf.rd_data !== exp_d || bf.level !== 5'd1) begin n_bad++; $display("FAIL arst_after got v=%b d=%h level=%0d required v=1 d=%h level=1", bf.rd_valid, bf.rd_data, bf.level, exp_d); end
    bf.rd_en = 1;
    @(negedge clk);
    bf.rd_en = 0;
    void'(qf.pop_front());
    n_cmp++; if (bf.empty !== 1'b1) begin n_bad++; $display("FAIL arst_drain got empty=%b required 1", bf.empty); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fill_drain();
    test_read_latency();
    test_back_to_back();
    test_thresholds();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
